// File: rtl/audio_ena_gen_if.sv
// Rate-request handshake and enable outputs of audio_ena_gen.
// SAMPLE_CNT exists only when AUDIO_ENA_CNT_EN is defined.
interface audio_ena_gen_if;
  logic [1:0]  RATE_SEL;
  logic        RATE_REQ;
  logic        RATE_ACK;
  logic        ENA;
  logic        ENA_OVS;
  logic [1:0]  RATE_CUR;
`ifdef AUDIO_ENA_CNT_EN
  logic [15:0] SAMPLE_CNT;

  modport master (output RATE_SEL, RATE_REQ,
                  input  RATE_ACK, ENA, ENA_OVS, RATE_CUR, SAMPLE_CNT);
  modport slave  (input  RATE_SEL, RATE_REQ,
                  output RATE_ACK, ENA, ENA_OVS, RATE_CUR, SAMPLE_CNT);
`else
  modport master (output RATE_SEL, RATE_REQ,
                  input  RATE_ACK, ENA, ENA_OVS, RATE_CUR);
  modport slave  (input  RATE_SEL, RATE_REQ,
                  output RATE_ACK, ENA, ENA_OVS, RATE_CUR);
`endif
endinterface

// File: rtl/audio_ena_gen.sv
// Phase-accumulator audio sample/oversample enable generator with glitch-free rate switching.
// Optional SAMPLE_CNT output enabled by defining AUDIO_ENA_CNT_EN.
module audio_ena_gen #(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned OVS        = 512,
  parameter int unsigned ACC_W      = 32,
  parameter int unsigned RESET_RATE = 0
) (
  input  logic            CLK_100M,
  input  logic            RST_N,
  audio_ena_gen_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(OVS);

  function automatic logic [ACC_W-1:0] calc_inc(input int unsigned rate_hz);
    logic [127:0] num;
    num = (128'(rate_hz) * 128'(OVS)) << ACC_W;
    calc_inc = ACC_W'((num + 128'(CLK_HZ / 2)) / 128'(CLK_HZ));
  endfunction

  // Index order: 0=48000, 1=44100, 2=96000, 3=32000 Hz.
  localparam logic [3:0][ACC_W-1:0] INC_TAB = {calc_inc(32000), calc_inc(96000),
                                                calc_inc(44100), calc_inc(48000)};

  generate
    if (64'(OVS) * 64'd96000 >= 64'(CLK_HZ)) begin : g_bad_clk
      $error("audio_ena_gen: OVS*96000 must be below CLK_HZ");
    end
    if (OVS < 2 || OVS > 1024 || (OVS & (OVS - 1)) != 0) begin : g_bad_ovs
      $error("audio_ena_gen: OVS must be a power of two in 2..1024");
    end
    if (ACC_W < 24 || ACC_W > 40) begin : g_bad_acc
      $error("audio_ena_gen: ACC_W must be in 24..40");
    end
    if (RESET_RATE > 3) begin : g_bad_rate
      $error("audio_ena_gen: RESET_RATE must be 0..3");
    end
  endgenerate

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] ovs_cnt_q, ovs_cnt_d;
  logic             ena_q, ena_d;
  logic             ena_ovs_q, ena_ovs_d;
  logic             ack_q, ack_d;
  logic [1:0]       rate_cur_q, rate_cur_d;
  logic             pend_q, pend_d;
  logic [1:0]       pend_idx_q, pend_idx_d;

  logic [ACC_W:0]   sum;
  logic             carry;
  logic             apply;

  always_ff @(posedge CLK_100M or negedge RST_N) begin
    if (!RST_N) begin
      acc_q      <= '0;
      ovs_cnt_q  <= '0;
      ena_q      <= 1'b0;
      ena_ovs_q  <= 1'b0;
      ack_q      <= 1'b0;
      rate_cur_q <= 2'(RESET_RATE);
      pend_q     <= 1'b0;
      pend_idx_q <= 2'd0;
    end else begin
      acc_q      <= acc_d;
      ovs_cnt_q  <= ovs_cnt_d;
      ena_q      <= ena_d;
      ena_ovs_q  <= ena_ovs_d;
      ack_q      <= ack_d;
      rate_cur_q <= rate_cur_d;
      pend_q     <= pend_d;
      pend_idx_q <= pend_idx_d;
    end
  end

  always_comb begin
    sum       = {1'b0, acc_q} + {1'b0, INC_TAB[rate_cur_q]};
    carry     = sum[ACC_W];
    acc_d     = sum[ACC_W-1:0];
    ena_ovs_d = carry;
    ovs_cnt_d = carry ? ovs_cnt_q + CNT_W'(1) : ovs_cnt_q;
    ena_d     = carry && (ovs_cnt_q == CNT_W'(OVS - 1));

    // Switch only on a sample boundary; a request arriving in that same
    // cycle becomes the next pending rate rather than the applied one.
    apply      = ena_q && pend_q;
    rate_cur_d = apply ? pend_idx_q : rate_cur_q;
    ack_d      = apply;
    pend_idx_d = bus.RATE_REQ ? bus.RATE_SEL : pend_idx_q;
    if (bus.RATE_REQ) begin
      pend_d = 1'b1;
    end else if (apply) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
  end

  assign bus.ENA      = ena_q;
  assign bus.ENA_OVS  = ena_ovs_q;
  assign bus.RATE_ACK = ack_q;
  assign bus.RATE_CUR = rate_cur_q;

`ifdef AUDIO_ENA_CNT_EN
  logic [15:0] sample_cnt_q, sample_cnt_d;

  always_comb sample_cnt_d = ena_d ? sample_cnt_q + 16'd1 : sample_cnt_q;

  always_ff @(posedge CLK_100M or negedge RST_N) begin
    if (!RST_N) begin
      sample_cnt_q <= 16'd0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
    end
  end

  assign bus.SAMPLE_CNT = sample_cnt_q;
`else
  // No sample counter in this build.
`endif

endmodule

// File: doc/audio_ena_gen.md
AUDIO_ENA_GEN -- requirements
Module: audio_ena_gen

Interface
REQ-001 Parameter CLK_HZ, default 100000000, input clock frequency in Hz.
REQ-002 Parameter OVS, default 512, oversampling factor; power of two, 2..1024.
REQ-003 Parameter ACC_W, default 32, phase accumulator width in bits, 24..40.
REQ-004 Parameter RESET_RATE, default 0, rate index loaded at reset.
REQ-005 CLK_100M  input  1  system clock; single clock domain.
REQ-006 RST_N  input  1  reset; asynchronous, active-low.
REQ-007 RATE_SEL  input  2  requested rate index: 0=48000, 1=44100, 2=96000, 3=32000 Hz.
REQ-008 RATE_REQ  input  1  one-cycle strobe that latches RATE_SEL as the pending rate.
REQ-009 RATE_ACK  output  1  one-cycle pulse when the pending rate takes effect.
REQ-010 ENA  output  1  one-cycle pulse at the sample rate.
REQ-011 ENA_OVS  output  1  one-cycle pulse at OVS x sample rate.
REQ-012 RATE_CUR  output  2  index of the rate currently in effect.

Function
REQ-013 Per-rate increment INC[i] SHALL be the elaboration-time constant round(rate_i*OVS*2^ACC_W/CLK_HZ); elaboration SHALL fail when OVS*96000 >= CLK_HZ.
REQ-014 Every cycle, acc <= (acc + INC[RATE_CUR]) mod 2^ACC_W; carry = bit ACC_W of the unwrapped sum.
REQ-015 ENA_OVS SHALL be registered: high in the cycle after a carry, low otherwise; at most one pulse per cycle, no missed carries.
REQ-016 ovs_cnt (log2(OVS) bits) SHALL increment on each carry and wrap OVS-1 -> 0.
REQ-017 ENA SHALL be registered: high in the same cycle as the ENA_OVS pulse whose carry wrapped ovs_cnt from OVS-1 to 0.
REQ-018 Long-run ENA_OVS rate SHALL equal CLK_HZ*INC/2^ACC_W; cycle spacing varies by at most 1 between pulses (no drift accumulation).
REQ-019 On RATE_REQ, RATE_SEL SHALL be captured as pending and a pending flag set; a further RATE_REQ while pending overwrites the pending index (last wins).
REQ-020 A pending rate SHALL be applied only at a sample boundary: in the cycle ENA is high, RATE_CUR <= pending, flag cleared; new INC used from the next cycle.
REQ-021 RATE_ACK SHALL pulse for one cycle, in the cycle after RATE_CUR updates.
REQ-022 RATE_REQ coinciding with an ENA pulse SHALL be held pending until the next ENA (not applied in that cycle).
REQ-023 Request for the already-current index SHALL still complete normally and produce RATE_ACK.
REQ-024 acc and ovs_cnt SHALL NOT be cleared on a rate change (phase-continuous switch).

Reset
REQ-025 While RST_N is low: acc=0, ovs_cnt=0, pending flag=0, ENA=0, ENA_OVS=0, RATE_ACK=0, RATE_CUR=RESET_RATE, asynchronously.
REQ-026 Reset asserted mid-operation SHALL discard any pending request; first ENA_OVS after release occurs at the first carry from acc=0.

Configuration
REQ-027 With AUDIO_ENA_CNT_EN defined, output SAMPLE_CNT (16 bits) SHALL count ENA pulses, wrap 65535 -> 0, reset to 0.
REQ-028 Without AUDIO_ENA_CNT_EN, SAMPLE_CNT and its counter SHALL be absent; all other behaviour identical.

Verification (defaults, CLK_HZ=100e6, OVS=512, ACC_W=32; INC[0]=1055531163)
REQ-029 Reset release, RATE 0, run 1,000,000 cycles -> ENA count 480+-1, ENA_OVS count 245760+-1, ENA_OVS spacing 4 or 5 cycles only.
REQ-030 RATE_REQ with RATE_SEL=2 mid-sample -> RATE_CUR changes exactly in the ENA cycle, RATE_ACK one cycle later; then ENA_OVS spacing 2 or 3 cycles, 960+-1 ENA per 1,000,000 cycles.
REQ-031 Two RATE_REQs (SEL=1 then SEL=3) before one ENA -> single RATE_ACK, RATE_CUR=3.
REQ-032 RATE_REQ in the same cycle as ENA -> applied at the following ENA, not the current one.
REQ-033 RST_N pulsed low asynchronously between clock edges with request pending -> all outputs 0, RATE_CUR=RESET_RATE immediately; no RATE_ACK after release.
REQ-034 With AUDIO_ENA_CNT_EN, run 65537 ENA pulses -> SAMPLE_CNT wraps and reads 1.
